// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame geometry from HS_/VS_/DE, locks once
// two consecutive frames agree, and regenerates active-area X/Y aligned to DE_O.
module vga_timing_rx #(
  parameter int XW = 12,
  parameter int YW = 11
) (
  input  logic          CLK,
  input  logic          RST_,
  input  logic          HS_,
  input  logic          VS_,
  input  logic          DE,
  output logic          DE_O,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic [XW-1:0] HTOTAL,
  output logic [XW-1:0] HACT,
  output logic [YW-1:0] VTOTAL,
  output logic [YW-1:0] VACT,
  output logic          LOCKED,
  output logic          ERR
);
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCK} state_e;

  localparam logic [XW-1:0] HMAX = '1;
  localparam logic [YW-1:0] VMAX = '1;
  localparam logic [XW-1:0] XONE = XW'(1);
  localparam logic [YW-1:0] YONE = YW'(1);

  state_e        state_q, state_d;
  logic          hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_d_q;
  logic          hfall, vfall, tmo;
  logic [XW-1:0] hcnt_q, hde_q, hp_last_q, hd_last_q, hp;
  logic          line_de_q;
  logic [YW-1:0] lcnt_q, lact_q;
  logic [XW-1:0] cand_hp, cand_hd, ref_hp_q, ref_hd_q, htot_q, hact_q;
  logic [YW-1:0] cand_vt, cand_va, ref_vt_q, ref_va_q, vtot_q, vact_q;
  logic          err_q, err_d, load_ref, publish, match_ref, match_pub;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          xnew_q, ynew_q, xf, yf;

  assign hfall = hs_p_q & ~hs_q;
  assign vfall = vs_p_q & ~vs_q;
  assign tmo   = (hcnt_q == HMAX);
  assign hp    = hcnt_q + XONE;

  // A vfall that lands on an hfall closes the line first, so bypass the
  // per-line captures into the frame candidate.
  assign cand_hp = hfall ? hp : hp_last_q;
  assign cand_hd = (hfall && line_de_q) ? hde_q : hd_last_q;
  assign cand_vt = lcnt_q + {{(YW-1){1'b0}}, hfall};
  assign cand_va = lact_q + {{(YW-1){1'b0}}, hfall & line_de_q};

  assign match_ref = (cand_hp == ref_hp_q) && (cand_hd == ref_hd_q) &&
                     (cand_vt == ref_vt_q) && (cand_va == ref_va_q);
  assign match_pub = (cand_hp == htot_q) && (cand_hd == hact_q) &&
                     (cand_vt == vtot_q) && (cand_va == vact_q);

  // The hfall cycle's de_q belongs to the new line.
  assign xf = xnew_q | hfall;
  assign yf = ynew_q | vfall;

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    load_ref = 1'b0;
    publish  = 1'b0;
    if (tmo) begin
      state_d = ST_SEARCH;
      err_d   = (state_q == ST_LOCK);
    end else begin
      case (state_q)
        ST_SEARCH:  if (vfall) state_d = ST_MEASURE;
        ST_MEASURE: if (vfall) begin
          load_ref = 1'b1;
          state_d  = ST_VERIFY;
        end
        ST_VERIFY:  if (vfall) begin
          if (match_ref) begin
            publish = 1'b1;
            state_d = ST_LOCK;
          end else begin
            load_ref = 1'b1;
          end
        end
        ST_LOCK: begin
          if (hfall && (hp != htot_q)) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end else if (vfall && !match_pub) begin
            err_d    = 1'b1;
            load_ref = 1'b1;
            state_d  = ST_VERIFY;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q <= ST_SEARCH;
      {hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_d_q} <= '0;
      hcnt_q <= '0;  hde_q <= '0;  hp_last_q <= '0;  hd_last_q <= '0;
      line_de_q <= 1'b0;
      lcnt_q <= '0;  lact_q <= '0;
      ref_hp_q <= '0;  ref_hd_q <= '0;  ref_vt_q <= '0;  ref_va_q <= '0;
      htot_q <= '0;  hact_q <= '0;  vtot_q <= '0;  vact_q <= '0;
      err_q <= 1'b0;
      x_q <= '0;  y_q <= '0;  xnew_q <= 1'b0;  ynew_q <= 1'b0;
    end else begin
      hs_q   <= HS_;
      vs_q   <= VS_;
      de_q   <= DE;
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
      de_d_q <= de_q;

      // hd_last tracks the most recent line that carried DE, so vertical
      // blanking lines before VS_ do not hide the active width.
      if (hfall) begin
        hcnt_q    <= '0;
        hp_last_q <= hp;
        if (line_de_q) hd_last_q <= hde_q;
        hde_q     <= {{(XW-1){1'b0}}, de_q};
        line_de_q <= de_q;
      end else begin
        if (!tmo) hcnt_q <= hcnt_q + XONE;
        if (de_q && (hde_q != HMAX)) hde_q <= hde_q + XONE;
        line_de_q <= line_de_q | de_q;
      end

      if (vfall) begin
        lcnt_q <= '0;
        lact_q <= '0;
      end else if (hfall) begin
        if (lcnt_q != VMAX) lcnt_q <= lcnt_q + YONE;
        if (line_de_q && (lact_q != VMAX)) lact_q <= lact_q + YONE;
      end

      if (de_q) begin
        if (xf) begin
          x_q <= '0;
          y_q <= yf ? '0 : y_q + YONE;
        end else begin
          x_q <= x_q + XONE;
        end
      end
      xnew_q <= xf & ~de_q;
      ynew_q <= yf & ~de_q;

      if (load_ref) begin
        ref_hp_q <= cand_hp;
        ref_hd_q <= cand_hd;
        ref_vt_q <= cand_vt;
        ref_va_q <= cand_va;
      end
      if (publish) begin
        htot_q <= cand_hp;
        hact_q <= cand_hd;
        vtot_q <= cand_vt;
        vact_q <= cand_va;
      end

      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign LOCKED = (state_q == ST_LOCK);
  assign ERR    = err_q;
  assign DE_O   = de_d_q & LOCKED;
  assign X      = x_q;
  assign Y      = y_q;
  assign HTOTAL = htot_q;
  assign HACT   = hact_q;
  assign VTOTAL = vtot_q;
  assign VACT   = vact_q;
endmodule
